data_mem_responder: RTL and testbench

Memory-side responder for the processor's data-memory interface. Samples the control unit's single-cycle `M_READ`/`M_WRITE` strobes together with the current MAR address and MDR write data. Performs the access on a synchronous single-port RAM and returns read data to the MDR with a one-cycle load pulse. Sits between the control state machine / MAR-MDR datapath and the data RAM, and buffers one request that arrives while busy.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_req_buf.sv | 43 ++++
 rtl/data_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding, op codes
// and default widths.
package dmem_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_RD_LAT    = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_req_buf.sv
// One-entry pending request buffer. A push is accepted only into an empty entry;
// a push against a full entry is reported on ovf and the request is lost.
module dmem_req_buf
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  op_t               push_op,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_wdata,
  output logic              vld,
  output logic              vld_nxt,
  output op_t               op,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              ovf
);

  logic accept;

  assign accept  = push & ~vld;
  assign ovf     = push & vld;
  assign vld_nxt = accept | (vld & ~pop);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) vld <= 1'b0;
    else        vld <= vld_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      op    <= push_op;
      addr  <= push_addr;
      wdata <= push_wdata;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder between the control FSM / MAR-MDR datapath and a synchronous
// single-port RAM. Define DMEM_BOUNDS_CHECK_EN to add address bounds checking (err_oob).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              M_READ,
  input  logic              M_WRITE,
  input  logic              clear,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] mdr_rdata,
  output logic              mdr_load,
  output logic              mem_busy,
  output logic              err_ovf,
  output logic              err_conf,
`ifdef DMEM_BOUNDS_CHECK_EN
  output logic              err_oob,
`endif
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              rd_p0, wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              conf_p0, req_p0;
  op_t               req_op_p0;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              start, start_oob, cur_oob;
  op_t               start_op;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_wdata;

  logic              buf_push, buf_pop, buf_vld, buf_vld_nxt, buf_ovf;
  op_t               buf_op;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;

  // Stage p0: register strobes and operands so no input reaches an output combinationally
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rd_p0 <= 1'b0;
      wr_p0 <= 1'b0;
    end else begin
      rd_p0 <= M_READ;
      wr_p0 <= M_WRITE;
    end
  end

  always_ff @(posedge clk_in) begin
    addr_p0  <= mar_addr;
    wdata_p0 <= mdr_wdata;
  end

  assign conf_p0   = rd_p0 & wr_p0;
  assign req_p0    = rd_p0 ^ wr_p0;
  assign req_op_p0 = wr_p0 ? OP_WR : OP_RD;
  // A valid entry blocks new strobes even in IDLE so requests stay in order
  assign buf_push  = req_p0 & ((state != IDLE) | buf_vld);
  assign start_oob = CHK_EN && (32'(start_addr) >= 32'(MEM_DEPTH));

  dmem_req_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_buf (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .push       (buf_push),
    .pop        (buf_pop),
    .push_op    (req_op_p0),
    .push_addr  (addr_p0),
    .push_wdata (wdata_p0),
    .vld        (buf_vld),
    .vld_nxt    (buf_vld_nxt),
    .op         (buf_op),
    .addr       (buf_addr),
    .wdata      (buf_wdata),
    .ovf        (buf_ovf)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    buf_pop     = 1'b0;
    start       = 1'b0;
    start_op    = req_op_p0;
    start_addr  = addr_p0;
    start_wdata = wdata_p0;
    case (state)
      IDLE: begin
        if (buf_vld) begin
          buf_pop     = 1'b1;
          start       = 1'b1;
          start_op    = buf_op;
          start_addr  = buf_addr;
          start_wdata = buf_wdata;
        end else if (req_p0) begin
          start = 1'b1;
        end
        if (start) state_nxt = (start_op == OP_WR) ? WR : RD_ISSUE;
      end
      WR:       state_nxt = IDLE;
      RD_ISSUE: begin
        cnt_nxt   = 2'(RD_LAT - 1);
        state_nxt = (RD_LAT == 1) ? RD_DONE : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = RD_DONE;
      end
      RD_DONE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered RAM command, read return and status flags
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cur_oob   <= 1'b0;
      mdr_rdata <= '0;
      mdr_load  <= 1'b0;
      mem_busy  <= 1'b0;
      err_ovf   <= 1'b0;
      err_conf  <= 1'b0;
    end else begin
      ram_en <= start & ~start_oob;
      ram_we <= start & (start_op == OP_WR) & ~start_oob;
      if (start) begin
        ram_addr  <= start_addr;
        ram_wdata <= start_wdata;
        cur_oob   <= start_oob;
      end
      mdr_load <= (state == RD_DONE);
      if (state == RD_DONE) mdr_rdata <= cur_oob ? '0 : ram_rdata;
      mem_busy <= (state_nxt != IDLE) | buf_vld_nxt;
      err_ovf  <= (err_ovf & ~clear) | buf_ovf;
      err_conf <= (err_conf & ~clear) | conf_p0;
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) err_oob <= 1'b0;
    else        err_oob <= (err_oob & ~clear) | (start & start_oob);
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (RD_LAT=1, RD_LAT=3,
// MEM_DEPTH=128) each with a behavioural RAM; read data is checked by a monitor.
module tb_data_mem_responder;

  localparam int NI = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst_n     [NI];
  logic       m_read    [NI];
  logic       m_write   [NI];
  logic       clear     [NI];
  logic [7:0] mar_addr  [NI];
  logic [7:0] mdr_wdata [NI];
  logic [7:0] mdr_rdata [NI];
  logic       mdr_load  [NI];
  logic       mem_busy  [NI];
  logic       err_ovf   [NI];
  logic       err_conf  [NI];
  logic       ram_en    [NI];
  logic       ram_we    [NI];
  logic [7:0] ram_addr  [NI];
  logic [7:0] ram_wdata [NI];
  logic [7:0] ram_rdata [NI];
`ifdef DMEM_BOUNDS_CHECK_EN
  logic       err_oob   [NI];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [NI][$];
  logic [7:0] mon_e;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : 1;
    logic [7:0] mem  [256];
    logic [7:0] pipe [3];

    always @(posedge clk_in) begin
      if (ram_en[g] && ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= (ram_en[g] && !ram_we[g]) ? mem[ram_addr[g]] : 8'hEE;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_rdata[g] = pipe[LAT-1];

    data_mem_responder #(
      .ADDR_W    (8),
      .DATA_W    (8),
      .MEM_DEPTH ((g == 2) ? 128 : 256),
      .RD_LAT    (LAT)
    ) u_dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n[g]),
      .M_READ    (m_read[g]),
      .M_WRITE   (m_write[g]),
      .clear     (clear[g]),
      .mar_addr  (mar_addr[g]),
      .mdr_wdata (mdr_wdata[g]),
      .mdr_rdata (mdr_rdata[g]),
      .mdr_load  (mdr_load[g]),
      .mem_busy  (mem_busy[g]),
      .err_ovf   (err_ovf[g]),
      .err_conf  (err_conf[g]),
`ifdef DMEM_BOUNDS_CHECK_EN
      .err_oob   (err_oob[g]),
`endif
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled on the following posedge.
  task automatic strobe(input int i, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
    m_read[i]    = rd;
    m_write[i]   = wr;
    mar_addr[i]  = a;
    mdr_wdata[i] = d;
    @(negedge clk_in);
    m_read[i]  = 1'b0;
    m_write[i] = 1'b0;
  endtask

  task automatic pulse_clear(input int i);
    clear[i] = 1'b1;
    @(negedge clk_in);
    clear[i] = 1'b0;
  endtask

  task automatic wait_load(input int i, input int max, output int n);
    n = -1;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk_in);
      if (mdr_load[i]) begin
        n = c;
        break;
      end
    end
  endtask

  function automatic logic [31:0] outs(input int i);
    return 32'({mdr_rdata[i], mdr_load[i], mem_busy[i], err_ovf[i], err_conf[i],
                ram_en[i], ram_we[i], ram_addr[i], ram_wdata[i]});
  endfunction

  always @(negedge clk_in) begin
    for (int i = 0; i < NI; i++) begin
      if (mdr_load[i]) begin
        if (exp_q[i].size() == 0) begin
          chk("unexpected_mdr_load", 32'(i), 32'hFFFF);
        end else begin
          mon_e = exp_q[i].pop_front();
          chk("mdr_rdata", 32'(mdr_rdata[i]), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  loads;
    bit  seen_en, seen_busy;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; m_read[i] = 1'b0; m_write[i] = 1'b0; clear[i] = 1'b0;
      mar_addr[i] = 8'h00; mdr_wdata[i] = 8'h00;
    end
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < NI; i++) chk("reset_outputs", outs(i), 0);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    @(negedge clk_in);

    // Write 0x5A to 0x10, then read it back (RD_LAT=1)
    strobe(0, 1'b0, 1'b1, 8'h10, 8'h5A);
    @(negedge clk_in);
    chk("wr_en_we", 32'({ram_en[0], ram_we[0]}), 'b11);
    chk("wr_addr", 32'(ram_addr[0]), 'h10);
    chk("wr_data", 32'(ram_wdata[0]), 'h5A);
    chk("wr_busy", 32'(mem_busy[0]), 1);
    @(negedge clk_in);
    chk("wr_done_busy_we", 32'({mem_busy[0], ram_we[0]}), 0);
    exp_q[0].push_back(8'h5A);
    strobe(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk_in);
    chk("rd_en_we", 32'({ram_en[0], ram_we[0]}), 'b10);
    chk("rd_addr", 32'(ram_addr[0]), 'h10);
    @(negedge clk_in);
    chk("rd_load_early", 32'(mdr_load[0]), 0);
    @(negedge clk_in);
    chk("rd_load_k3", 32'(mdr_load[0]), 1);
    @(negedge clk_in);
    chk("rd_load_width", 32'(mdr_load[0]), 0);
    chk("rd_busy_low", 32'(mem_busy[0]), 0);

    // Write, buffered read, dropped third strobe
    strobe(0, 1'b0, 1'b1, 8'h30, 8'h11);
    exp_q[0].push_back(8'h11);
    strobe(0, 1'b1, 1'b0, 8'h30, 8'h00);
    strobe(0, 1'b0, 1'b1, 8'h10, 8'hBB);
    wait_load(0, 10, n);
    chk("buf_rd_latency", 32'(n), 3);
    chk("ovf_set", 32'(err_ovf[0]), 1);
    pulse_clear(0);
    chk("ovf_cleared", 32'(err_ovf[0]), 0);
    exp_q[0].push_back(8'h5A);
    strobe(0, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_load(0, 10, n);
    chk("dropped_wr_latency", 32'(n), 3);

    // Read/write conflict
    strobe(0, 1'b1, 1'b1, 8'h20, 8'h33);
    seen_en = 1'b0; seen_busy = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      if (ram_en[0]) seen_en = 1'b1;
      if (mem_busy[0]) seen_busy = 1'b1;
    end
    chk("conf_flag", 32'(err_conf[0]), 1);
    chk("conf_no_ram_en", 32'(seen_en), 0);
    chk("conf_no_busy", 32'(seen_busy), 0);
    pulse_clear(0);
    chk("conf_cleared", 32'(err_conf[0]), 0);
    strobe(0, 1'b1, 1'b1, 8'h20, 8'h33);
    pulse_clear(0);
    chk("conf_clear_same_cycle", 32'(err_conf[0]), 1);
    pulse_clear(0);
    chk("conf_cleared_again", 32'(err_conf[0]), 0);

    // Reset during a write aborts ram_we immediately
    strobe(0, 1'b0, 1'b1, 8'h50, 8'h44);
    @(negedge clk_in);
    chk("abort_we_before", 32'(ram_we[0]), 1);
    rst_n[0] = 1'b0;
    #1;
    chk("abort_outputs", outs(0), 0);
    @(negedge clk_in);
    rst_n[0] = 1'b1;

    // RD_LAT=3
    strobe(1, 1'b0, 1'b1, 8'h03, 8'h77);
    repeat (2) @(negedge clk_in);
    exp_q[1].push_back(8'h77);
    strobe(1, 1'b1, 1'b0, 8'h03, 8'h00);
    wait_load(1, 10, n);
    chk("lat3_latency", 32'(n), 5);
    @(negedge clk_in);
    chk("lat3_load_width", 32'(mdr_load[1]), 0);

    // Reset during RD_WAIT
    strobe(1, 1'b1, 1'b0, 8'h03, 8'h00);
    repeat (2) @(negedge clk_in);
    chk("rdwait_busy", 32'(mem_busy[1]), 1);
    rst_n[1] = 1'b0;
    #1;
    chk("rdwait_reset_outputs", outs(1), 0);
    repeat (2) @(negedge clk_in);
    rst_n[1] = 1'b1;
    loads = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (mdr_load[1]) loads++;
    end
    chk("no_load_after_reset", 32'(loads), 0);
    exp_q[1].push_back(8'h77);
    strobe(1, 1'b1, 1'b0, 8'h03, 8'h00);
    wait_load(1, 10, n);
    chk("read_after_reset_latency", 32'(n), 5);

`ifdef DMEM_BOUNDS_CHECK_EN
    // MEM_DEPTH=128: out-of-range accesses never reach the RAM
    strobe(2, 1'b0, 1'b1, 8'hF0, 8'hC5);
    @(negedge clk_in);
    chk("oob_wr_no_en", 32'({ram_en[2], ram_we[2]}), 0);
    chk("oob_wr_flag", 32'(err_oob[2]), 1);
    pulse_clear(2);
    chk("oob_cleared", 32'(err_oob[2]), 0);
    exp_q[2].push_back(8'h00);
    strobe(2, 1'b1, 1'b0, 8'h90, 8'h00);
    @(negedge clk_in);
    chk("oob_rd_no_en", 32'(ram_en[2]), 0);
    wait_load(2, 10, n);
    chk("oob_rd_latency", 32'(n), 2);
    chk("oob_rd_flag", 32'(err_oob[2]), 1);
`else
    // Without bounds checking every address bit reaches the RAM
    strobe(2, 1'b0, 1'b1, 8'hF0, 8'hC5);
    @(negedge clk_in);
    chk("wide_wr_addr", 32'(ram_addr[2]), 'hF0);
    chk("wide_wr_we", 32'(ram_we[2]), 1);
    @(negedge clk_in);
    exp_q[2].push_back(8'hC5);
    strobe(2, 1'b1, 1'b0, 8'hF0, 8'h00);
    wait_load(2, 10, n);
    chk("wide_rd_latency", 32'(n), 3);
`endif

    repeat (3) @(negedge clk_in);
    for (int i = 0; i < NI; i++) chk("scoreboard_drained", 32'(exp_q[i].size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
